// File: rtl/dmem_bus_bridge.sv
// Bridges the single-cycle core data-memory port onto a variable-latency valid/ready bus.
// Optional alignment checking is enabled by defining DMEM_BRIDGE_MISALIGN_EN.
module dmem_bus_bridge #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core_re,
    input  logic                core_we,
    input  logic [DATA_W/8-1:0] core_be,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    output logic [DATA_W-1:0]   core_rdata,
    output logic                core_stall,
    output logic                core_err,
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic                bus_req_we,
    output logic [DATA_W/8-1:0] bus_req_be,
    output logic [ADDR_W-1:0]   bus_req_addr,
    output logic [DATA_W-1:0]   bus_req_wdata,
    input  logic                bus_rsp_valid,
    input  logic [DATA_W-1:0]   bus_rsp_rdata,
    input  logic                bus_rsp_err
);

    localparam int unsigned BeW     = DATA_W / 8;
    localparam int unsigned CntBits = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CntW    = (CntBits > 0) ? CntBits : 1;
    localparam logic [CntW-1:0] CntLast =
        CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReq, StRsp, StDone} state_e;

    state_e            state_q;
    logic              we_q;
    logic [BeW-1:0]    be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [CntW-1:0]   cnt_q;

    logic              access;
    logic              misaligned;
    logic              timeout_hit;
    logic [CntW-1:0]   cnt_inc;

    assign access = core_re | core_we;

`ifdef DMEM_BRIDGE_MISALIGN_EN
    logic [BeW-1:0] chk_be;
    assign chk_be     = core_we ? core_be : '1;
    assign misaligned = ((chk_be == '1) && (core_addr[1:0] != 2'b00)) ||
                        (((chk_be == BeW'(3)) || (chk_be == BeW'(12))) && core_addr[0]);
`else
    assign misaligned = 1'b0;
`endif

    // Counter holds its value once all-ones so it can never wrap back into range.
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q >= CntLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (access) begin
                        we_q    <= core_we;
                        be_q    <= core_we ? core_be : '1;
                        addr_q  <= core_addr;
                        wdata_q <= core_we ? core_wdata : '0;
                        cnt_q   <= '0;
                        if (misaligned) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            state_q <= StReq;
                        end
                    end
                end
                StReq: begin
                    cnt_q <= cnt_inc;
                    // A handshake on the final cycle still wins over the timeout.
                    if (bus_req_ready) begin
                        state_q <= StRsp;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StRsp: begin
                    cnt_q <= cnt_inc;
                    if (bus_rsp_valid) begin
                        rdata_q <= we_q ? '0 : bus_rsp_rdata;
                        err_q   <= bus_rsp_err;
                        state_q <= StDone;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus_req_valid = (state_q == StReq);
    assign bus_req_we    = we_q;
    assign bus_req_be    = be_q;
    assign bus_req_addr  = addr_q;
    assign bus_req_wdata = wdata_q;

    assign core_stall = ((state_q == StIdle) && access) || (state_q == StReq) ||
                        (state_q == StRsp);
    assign core_rdata = (state_q == StDone) ? rdata_q : '0;
    assign core_err   = (state_q == StDone) && err_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: each task drives one scenario and checks inline.
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_re = 1'b0;
    logic        core_we = 1'b0;
    logic [3:0]  core_be = '0;
    logic [31:0] core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        core_err;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic        bus_req_we;
    logic [3:0]  bus_req_be;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rsp_rdata = '0;
    logic        bus_rsp_err = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    dmem_bus_bridge #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .core_re      (core_re),
        .core_we      (core_we),
        .core_be      (core_be),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_rdata   (core_rdata),
        .core_stall   (core_stall),
        .core_err     (core_err),
        .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready),
        .bus_req_we   (bus_req_we),
        .bus_req_be   (bus_req_be),
        .bus_req_addr (bus_req_addr),
        .bus_req_wdata(bus_req_wdata),
        .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_rdata(bus_rsp_rdata),
        .bus_rsp_err  (bus_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus_req_valid, core_stall, core_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 000", {bus_req_valid, core_stall, core_err});
        end
        vectors++;
        if ({core_rdata, bus_req_addr, bus_req_wdata} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", {core_rdata, bus_req_addr, bus_req_wdata});
        end
    endtask

    task automatic test_load();
        core_re = 1'b1;
        core_addr = 32'h100;
        bus_req_ready = 1'b1;
        #1;
        vectors++;
        if ({core_stall, bus_req_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL load_idle: stall,valid got %b want 10", {core_stall, bus_req_valid});
        end
        tick();
        vectors++;
        if ({core_stall, bus_req_valid, bus_req_we, bus_req_be, bus_req_addr} !==
            {3'b110, 4'hF, 32'h100}) begin
            miscompares++;
            $display("FAIL load_req: got %b %h %h want 110 f 100",
                     {core_stall, bus_req_valid, bus_req_we}, bus_req_be, bus_req_addr);
        end
        tick();
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hDEADBEEF;
        #1;
        vectors++;
        if ({core_stall, bus_req_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL load_rsp: stall,valid got %b want 10", {core_stall, bus_req_valid});
        end
        tick();
        bus_rsp_valid = 1'b0;
        core_re = 1'b0;
        #1;
        vectors++;
        if ({core_stall, core_err, core_rdata} !== {2'b00, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL load_done: got %b %h want 00 deadbeef", {core_stall, core_err}, core_rdata);
        end
        tick();
        vectors++;
        if ({core_stall, core_err, core_rdata} !== 34'h0) begin
            miscompares++;
            $display("FAIL load_after: got %b %h want 00 0", {core_stall, core_err}, core_rdata);
        end
    endtask

    task automatic test_store_wait();
        int accepts = 0;
        core_we = 1'b1;
        core_be = 4'b0011;
        core_addr = 32'h20;
        core_wdata = 32'h1234;
        bus_req_ready = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if ({bus_req_valid, bus_req_we, bus_req_be, bus_req_addr, bus_req_wdata} !==
                {2'b11, 4'b0011, 32'h20, 32'h1234}) begin
                miscompares++;
                $display("FAIL store_req_stable[%0d]: got %b %h %h %h", i,
                         {bus_req_valid, bus_req_we}, bus_req_be, bus_req_addr, bus_req_wdata);
            end
            if (i == 5) bus_req_ready = 1'b1;
            #1;
            if (bus_req_valid && bus_req_ready) accepts++;
            tick();
        end
        bus_req_ready = 1'b1;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hFFFFFFFF;
        #1;
        if (bus_req_valid && bus_req_ready) accepts++;
        vectors++;
        if (accepts !== 1) begin
            miscompares++;
            $display("FAIL store_accepts: got %0d want 1", accepts);
        end
        tick();
        bus_rsp_valid = 1'b0;
        bus_req_ready = 1'b0;
        core_we = 1'b0;
        #1;
        vectors++;
        if ({core_stall, core_err, core_rdata} !== 34'h0) begin
            miscompares++;
            $display("FAIL store_done: got %b %h want 00 0", {core_stall, core_err}, core_rdata);
        end
        tick();
    endtask

    task automatic test_both_set();
        core_re = 1'b1;
        core_we = 1'b1;
        core_be = 4'b0101;
        core_addr = 32'h80;
        core_wdata = 32'hA5A5A5A5;
        bus_req_ready = 1'b1;
        tick();
        vectors++;
        if ({bus_req_valid, bus_req_we, bus_req_be, bus_req_wdata} !==
            {2'b11, 4'b0101, 32'hA5A5A5A5}) begin
            miscompares++;
            $display("FAIL both_req: got %b %h %h want 11 5 a5a5a5a5",
                     {bus_req_valid, bus_req_we}, bus_req_be, bus_req_wdata);
        end
        tick();
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_err = 1'b1;
        bus_rsp_rdata = 32'h12345678;
        tick();
        bus_rsp_valid = 1'b0;
        bus_rsp_err = 1'b0;
        core_re = 1'b0;
        core_we = 1'b0;
        #1;
        vectors++;
        if ({core_stall, core_err, core_rdata} !== {2'b01, 32'h0}) begin
            miscompares++;
            $display("FAIL both_done: got %b %h want 01 0", {core_stall, core_err}, core_rdata);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        // Accepted request, no response: 1 REQ + 7 RSP cycles.
        core_re = 1'b1;
        core_addr = 32'h40;
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        n = 0;
        while (core_stall && n < 30) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== 8) begin
            miscompares++;
            $display("FAIL timeout_rsp_cycles: got %0d want 8", n);
        end
        vectors++;
        if ({core_err, core_rdata, bus_req_valid} !== {1'b1, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL timeout_rsp_done: err %b rdata %h valid %b want 1 0 0",
                     core_err, core_rdata, bus_req_valid);
        end
        core_re = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'h55;
        tick();
        tick();
        vectors++;
        if ({core_stall, core_err, core_rdata, bus_req_valid} !== 35'h0) begin
            miscompares++;
            $display("FAIL timeout_late_rsp: got %b %h", {core_stall, core_err, bus_req_valid},
                     core_rdata);
        end
        bus_rsp_valid = 1'b0;
        // Never accepted: valid must drop after 8 REQ cycles.
        core_we = 1'b1;
        core_be = 4'hF;
        core_addr = 32'h44;
        tick();
        n = 0;
        while (core_stall && n < 30) begin
            tick();
            n++;
        end
        vectors++;
        if ({n[7:0], core_err, bus_req_valid} !== {8'd8, 2'b10}) begin
            miscompares++;
            $display("FAIL timeout_req: cycles %0d err %b valid %b want 8 1 0", n, core_err,
                     bus_req_valid);
        end
        core_we = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        core_re = 1'b1;
        core_addr = 32'h200;
        bus_req_ready = 1'b1;
        tick();
        tick();
        bus_req_ready = 1'b0;
        reset = 1'b1;
        core_re = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus_req_valid, core_stall, core_err, bus_req_we, bus_req_be, bus_req_addr,
             core_rdata} !== 72'h0) begin
            miscompares++;
            $display("FAIL reset_mid: valid %b stall %b addr %h be %h", bus_req_valid,
                     core_stall, bus_req_addr, bus_req_be);
        end
        core_re = 1'b1;
        core_addr = 32'h204;
        bus_req_ready = 1'b1;
        tick();
        tick();
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'h600DF00D;
        tick();
        bus_rsp_valid = 1'b0;
        core_re = 1'b0;
        #1;
        vectors++;
        if ({core_stall, core_err, core_rdata} !== {2'b00, 32'h600DF00D}) begin
            miscompares++;
            $display("FAIL reset_mid_next: got %b %h want 00 600df00d", {core_stall, core_err},
                     core_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        core_re = 1'b1;
        core_addr = 32'h300;
        bus_req_ready = 1'b1;
        tick();
        tick();
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'h11111111;
        tick();
        bus_rsp_valid = 1'b0;
        core_addr = 32'h304;
        tick();
        vectors++;
        if ({core_stall, bus_req_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_reaccept: stall,valid got %b want 10", {core_stall, bus_req_valid});
        end
        tick();
        vectors++;
        if ({bus_req_valid, bus_req_addr} !== {1'b1, 32'h304}) begin
            miscompares++;
            $display("FAIL b2b_second_req: got %b %h want 1 304", bus_req_valid, bus_req_addr);
        end
        tick();
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'h22222222;
        tick();
        bus_rsp_valid = 1'b0;
        core_re = 1'b0;
        #1;
        vectors++;
        if (core_rdata !== 32'h22222222) begin
            miscompares++;
            $display("FAIL b2b_second_data: got %h want 22222222", core_rdata);
        end
        tick();
    endtask

    task automatic test_misalign();
        core_re = 1'b1;
        core_addr = 32'h102;
        bus_req_ready = 1'b0;
`ifdef DMEM_BRIDGE_MISALIGN_EN
        #1;
        vectors++;
        if ({core_stall, bus_req_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL misalign_idle: got %b want 10", {core_stall, bus_req_valid});
        end
        tick();
        core_re = 1'b0;
        #1;
        vectors++;
        if ({core_stall, core_err, bus_req_valid, core_rdata} !== {3'b010, 32'h0}) begin
            miscompares++;
            $display("FAIL misalign_done: got %b %h want 010 0",
                     {core_stall, core_err, bus_req_valid}, core_rdata);
        end
        tick();
`else
        tick();
        vectors++;
        if ({bus_req_valid, bus_req_be, bus_req_addr} !== {1'b1, 4'hF, 32'h102}) begin
            miscompares++;
            $display("FAIL misalign_fwd: got %b %h %h want 1 f 102", bus_req_valid, bus_req_be,
                     bus_req_addr);
        end
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hCAFE0102;
        tick();
        bus_rsp_valid = 1'b0;
        core_re = 1'b0;
        #1;
        vectors++;
        if ({core_err, core_rdata} !== {1'b0, 32'hCAFE0102}) begin
            miscompares++;
            $display("FAIL misalign_fwd_done: got %b %h want 0 cafe0102", core_err, core_rdata);
        end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_wait();
        test_both_set();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
